// File: rtl/aes_cipher_top.sv
// AES-128 forward cipher, iterative, one round per clock, on-the-fly key expansion; done pulses 10 cycles after ld.
// Optional busy output is compiled in only when AES_CIPHER_BUSY_EN is defined.

module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform.
   function automatic logic [7:0] sbox_f(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240, b;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      b    = gf_mul(gf_mul(x240, x12), x2);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   assign y_o = sbox_f(a_i);
endmodule

module aes_cipher_top (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [127:0] key,
   input  logic [127:0] text_in,
   output logic [127:0] text_out,
   output logic         done
`ifdef AES_CIPHER_BUSY_EN
   ,
   output logic         busy
`endif
);
   typedef enum logic {IDLE, RUN} fsm_e;

   fsm_e         fsm_q;
   logic [3:0]   rcnt_q;
   logic [127:0] state_q;
   logic [127:0] rk_q;
   logic [127:0] text_out_q;
   logic         done_q;

   logic [7:0]   sb_out [16];
   logic [7:0]   sr     [16];
   logic [7:0]   mc     [16];
   logic [31:0]  ksub;
   logic [7:0]   rcon;
   logic [127:0] rk_d;
   logic [127:0] round_d;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   genvar gi;
   for (gi = 0; gi < 16; gi++) begin : g_sbox
      aes_sbox u_sbox (.a_i(state_q[127-8*gi -: 8]), .y_o(sb_out[gi]));
   end

   // SubWord(RotWord(w3)) for the key schedule; these four are separate from the 16 datapath S-boxes.
   for (gi = 0; gi < 4; gi++) begin : g_ksbox
      aes_sbox u_ksbox (.a_i(rk_q[31-8*((gi+1)%4) -: 8]), .y_o(ksub[31-8*gi -: 8]));
   end

   always_comb begin
      case (rcnt_q)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   always_comb begin
      logic [31:0] w0, w1, w2, w3;
      w0   = rk_q[127:96] ^ ksub ^ {rcon, 24'h000000};
      w1   = rk_q[95:64] ^ w0;
      w2   = rk_q[63:32] ^ w1;
      w3   = rk_q[31:0] ^ w2;
      rk_d = {w0, w1, w2, w3};
   end

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[4*c+r] = sb_out[4*((c+r)%4)+r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[4*c+0] = xt(sr[4*c+0]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c+0] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xt(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
      end
      // Final round skips MixColumns.
      for (int i = 0; i < 16; i++) begin
         round_d[127-8*i -: 8] = ((rcnt_q == 4'd10) ? sr[i] : mc[i]) ^ rk_d[127-8*i -: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q      <= IDLE;
         rcnt_q     <= 4'd0;
         state_q    <= 128'h0;
         rk_q       <= 128'h0;
         text_out_q <= 128'h0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm_q)
            IDLE: begin
               if (ld) begin
                  state_q <= text_in ^ key;
                  rk_q    <= key;
                  rcnt_q  <= 4'd1;
                  fsm_q   <= RUN;
               end
            end
            RUN: begin
               state_q <= round_d;
               rk_q    <= rk_d;
               rcnt_q  <= rcnt_q + 4'd1;
               if (rcnt_q == 4'd10) begin
                  text_out_q <= round_d;
                  done_q     <= 1'b1;
                  rcnt_q     <= 4'd0;
                  fsm_q      <= IDLE;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

`ifdef AES_CIPHER_BUSY_EN
   logic busy_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= 1'b0;
      end else if (fsm_q == IDLE) begin
         busy_q <= ld;
      end else begin
         busy_q <= (rcnt_q != 4'd10);
      end
   end
   assign busy = busy_q;
`endif

   assign text_out = text_out_q;
   assign done     = done_q;
endmodule

// File: tb/tb_aes_cipher_top.sv
// Scoreboard bench for aes_cipher_top: issued blocks push expected ciphertext and done cycle,
// a negedge monitor pops on done and also checks hold, reset and busy behaviour.
module tb_aes_cipher_top;
   logic         clk = 1'b0;
   logic         rst;
   logic         ld;
   logic [127:0] key;
   logic [127:0] text_in;
   logic [127:0] text_out;
   logic         done;
`ifdef AES_CIPHER_BUSY_EN
   logic         busy;
`endif

   aes_cipher_top dut (
      .clk(clk), .rst(rst), .ld(ld), .key(key), .text_in(text_in),
      .text_out(text_out), .done(done)
`ifdef AES_CIPHER_BUSY_EN
      , .busy(busy)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] ct;
      int           cyc;
   } exp_t;

   exp_t         exp_q[$];
   int           cyc = 0;
   int           free_at = 0;
   int           n_tests = 0;
   int           n_fail = 0;
   logic [127:0] last_ct = 128'h0;
   logic [7:0]   sbox_t [256];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] tb_xt(input logic [7:0] b);
      return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box generated by walking the multiplicative group with generator 3.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                  ^ {rc, 24'h0};
            rc = tb_xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               t[4*c+rr] = sbox_t[s[4*((c+rr)%4)+rr]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               s[4*c+0] = tb_xt(t[4*c+0]) ^ tb_xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c+0] ^ tb_xt(t[4*c+1]) ^ tb_xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+2] = t[4*c+0] ^ t[4*c+1] ^ tb_xt(t[4*c+2]) ^ tb_xt(t[4*c+3]) ^ t[4*c+3];
               s[4*c+3] = tb_xt(t[4*c+0]) ^ t[4*c+0] ^ t[4*c+1] ^ t[4*c+2] ^ tb_xt(t[4*c+3]);
            end else begin
               for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One-cycle ld pulse; the model decides whether the DUT is free to accept it.
   task automatic issue(input logic [127:0] k, input logic [127:0] t,
                        input logic [127:0] ct, input bit use_ct);
      exp_t e;
      @(negedge clk);
      ld = 1'b1;
      key = k;
      text_in = t;
      @(posedge clk);
      #1;
      ld = 1'b0;
      key = rnd128();
      text_in = rnd128();
      if (rst && cyc >= free_at) begin
         e.ct  = use_ct ? ct : aes_ref(k, t);
         e.cyc = cyc + 10;
         exp_q.push_back(e);
         free_at = cyc + 11;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_done_timeout: %0d blocks pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0 && !done && cyc > exp_q[0].cyc) begin
         check("missing_done", {127'h0, done}, 128'h1);
         e = exp_q.pop_front();
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", {127'h0, done}, 128'h0);
         end else begin
            e = exp_q.pop_front();
            check("ciphertext", text_out, e.ct);
            check("done_cycle", 128'(cyc), 128'(e.cyc));
            last_ct = e.ct;
         end
      end else begin
         check("text_out_hold", text_out, last_ct);
      end
`ifdef AES_CIPHER_BUSY_EN
      check("busy", {127'h0, busy},
            {127'h0, (rst && exp_q.size() > 0 && cyc < exp_q[0].cyc)});
`endif
   end

   localparam logic [127:0] K27 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P27 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C27 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K28 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P28 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C28 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   initial begin
      build_sbox();
      rst = 1'b1;
      ld = 1'b0;
      key = 128'h0;
      text_in = 128'h0;
      #2 rst = 1'b0;
      #1;
      check("reset_text_out", text_out, 128'h0);
      check("reset_done", {127'h0, done}, 128'h0);
`ifdef AES_CIPHER_BUSY_EN
      check("reset_busy", {127'h0, busy}, 128'h0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      issue(K27, P27, C27, 1'b1);
      wait_idle();
      issue(K28, P28, C28, 1'b1);
      wait_idle();

      // Back-to-back: second ld lands on the edge right after the done edge.
      issue(128'h0, 128'h0, C0, 1'b1);
      repeat (10) @(posedge clk);
      issue(K27, P27, C27, 1'b1);
      wait_idle();

      // ld mid-block must be ignored.
      issue(K27, P27, C27, 1'b1);
      repeat (4) @(posedge clk);
      issue(K28, P28, C28, 1'b1);
      wait_idle();

      // Asynchronous reset part-way through a block.
      issue(K27, P27, C27, 1'b1);
      repeat (4) @(posedge clk);
      #3 rst = 1'b0;
      exp_q.delete();
      last_ct = 128'h0;
      free_at = 0;
      #1;
      check("midrst_done", {127'h0, done}, 128'h0);
      check("midrst_text_out", text_out, 128'h0);
`ifdef AES_CIPHER_BUSY_EN
      check("midrst_busy", {127'h0, busy}, 128'h0);
`endif
      issue(K28, P28, C28, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      issue(K28, P28, C28, 1'b1);
      wait_idle();

      for (int n = 0; n < 30; n++) begin
         issue(rnd128(), rnd128(), 128'h0, 1'b0);
         repeat ($urandom_range(0, 14)) @(posedge clk);
      end
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
